// File: rtl/signed_addsub_ctrl.sv
// Handshake/sequencing stage around an external ripple-carry adder: IDLE -> DRIVE -> HOLD.
// Optional macro SIGNED_SAT_EN clamps the result on signed overflow instead of wrapping.
module signed_addsub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  // operand side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  // external adder
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  // result side
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_neg,
  output logic [WIDTH-1:0] res_mag
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_cin;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_cout;
  logic             r_res_ovf;
  logic             r_res_neg;
  logic [WIDTH-1:0] r_res_mag;

  logic             w_accept;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag;

  // Handshake flags decode straight from the state register, so they never glitch.
  assign in_ready  = (r_state == S_IDLE);
  assign res_valid = (r_state == S_HOLD);
  assign w_accept  = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_DRIVE;
      S_DRIVE:                w_state_nxt = S_HOLD;
      S_HOLD:  if (res_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Signed overflow: both adder inputs agree in sign but the sum does not.
  // add_b already carries ~B for subtraction, so this covers A-B as well.
  assign w_ovf = (r_add_a[MSB] == r_add_b[MSB]) && (add_sum[MSB] != r_add_a[MSB]);

`ifdef SIGNED_SAT_EN
  always_comb begin
    w_res = add_sum;
    if (w_ovf) begin
      w_res = r_add_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_res = add_sum;
`endif

  // Most-negative value negates to itself; read unsigned it is the correct magnitude.
  assign w_neg = w_res[MSB];
  assign w_mag = w_neg ? (~w_res + WIDTH'(1)) : w_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_add_cin  <= 1'b0;
      r_res_sum  <= '0;
      r_res_cout <= 1'b0;
      r_res_ovf  <= 1'b0;
      r_res_neg  <= 1'b0;
      r_res_mag  <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_add_a   <= op_a;
        r_add_b   <= op_sub ? ~op_b : op_b;
        r_add_cin <= op_sub;
      end
      if (r_state == S_DRIVE) begin
        r_res_sum  <= w_res;
        r_res_cout <= add_cout;
        r_res_ovf  <= w_ovf;
        r_res_neg  <= w_neg;
        r_res_mag  <= w_mag;
      end
    end
  end

  assign add_a    = r_add_a;
  assign add_b    = r_add_b;
  assign add_cin  = r_add_cin;
  assign res_sum  = r_res_sum;
  assign res_cout = r_res_cout;
  assign res_ovf  = r_res_ovf;
  assign res_neg  = r_res_neg;
  assign res_mag  = r_res_mag;

endmodule

// File: tb/tb_signed_addsub_ctrl.sv
// Scoreboard bench for signed_addsub_ctrl with a behavioural 4-bit adder on the add_* port.
// Honours SIGNED_SAT_EN so the expected results follow the same build option as the DUT.
module tb_signed_addsub_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             op_sub = 1'b0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;
  logic             res_neg;
  logic [WIDTH-1:0] res_mag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       neg;
    logic [3:0] mag;
    logic [3:0] b_drv;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ripple-carry adder seen by the DUT.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  signed_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
    .res_neg(res_neg), .res_mag(res_mag)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model built from signed integer arithmetic, independent of the adder trick.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic sub);
    exp_t e;
    int sa, sb, r, u;
    sa = $signed(a);
    sb = $signed(b);
    r  = sub ? sa - sb : sa + sb;
    u  = int'(a) + (sub ? 15 - int'(b) : int'(b)) + int'(sub);
    e.cout  = u[4];
    e.ovf   = (r > 7) || (r < -8);
    e.sum   = 4'(r);
`ifdef SIGNED_SAT_EN
    if (e.ovf) e.sum = (r > 7) ? 4'd7 : 4'd8;
`endif
    e.neg   = e.sum[3];
    e.mag   = e.neg ? 4'(16 - int'(e.sum)) : e.sum;
    e.b_drv = sub ? ~b : b;
    return e;
  endfunction

  // One transaction: offer operands, check DRIVE, check result, optionally stall in HOLD.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input int hold, output int accept_cyc);
    exp_t e;
    int   n;
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    sb_q.push_back(model(a, b, sub));
    @(posedge clk); accept_cyc = cyc; #1;
    in_valid = 1'b0;
    e = sb_q[0];
    check("drive_in_ready", 32'(in_ready), 32'd0);
    check("drive_res_valid", 32'(res_valid), 32'd0);
    check("drive_add_a", 32'(add_a), 32'(a));
    check("drive_add_b", 32'(add_b), 32'(e.b_drv));
    check("drive_add_cin", 32'(add_cin), 32'(sub));
    @(posedge clk); #1;
    check("latency_res_valid", 32'(res_valid), 32'd1);
    e = sb_q.pop_front();
    check("res_sum", 32'(res_sum), 32'(e.sum));
    check("res_cout", 32'(res_cout), 32'(e.cout));
    check("res_ovf", 32'(res_ovf), 32'(e.ovf));
    check("res_neg", 32'(res_neg), 32'(e.neg));
    check("res_mag", 32'(res_mag), 32'(e.mag));
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      op_a = 4'($urandom); op_b = 4'($urandom); op_sub = 1'($urandom);
      @(posedge clk); #1;
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_res_sum", 32'(res_sum), 32'(e.sum));
      check("hold_res_mag", 32'(res_mag), 32'(e.mag));
      check("hold_add_a", 32'(add_a), 32'(a));
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("release_res_valid", 32'(res_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_keep_sum", 32'(res_sum), 32'(e.sum));
  endtask

  initial begin
    int acc, prev_acc;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_flags", 32'({res_cout, res_ovf, res_neg}), 32'd0);
    check("rst_res_mag", 32'(res_mag), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(4'd3, 4'd2, 1'b0, 0, acc);   // 3+2
    run_op(4'd7, 4'd1, 1'b0, 0, acc);   // 7+1 overflow
    run_op(4'd2, 4'd5, 1'b1, 0, acc);   // 2-5
    run_op(4'h8, 4'd1, 1'b1, 0, acc);   // -8-1 overflow, cout=1
    run_op(4'h8, 4'h8, 1'b1, 0, acc);   // -8-(-8), subtract zero boundary
    run_op(4'h8, 4'h8, 1'b0, 0, acc);   // -8+(-8) overflow
    run_op(4'hA, 4'd3, 1'b0, 5, acc);   // stall in HOLD with in_valid toggling

    // Back-to-back random operations: one accept every 3 cycles.
    run_op(4'($urandom), 4'($urandom), 1'($urandom), 0, prev_acc);
    for (int i = 0; i < 12; i++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom), 0, acc);
      check("throughput", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end

    // Reset during DRIVE drops the transaction.
    op_a = 4'd1; op_b = 4'd1; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_mid_in_drive", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_res_valid", 32'(res_valid), 32'd0);
    check("rst_mid_res_sum", 32'(res_sum), 32'd0);
    check("rst_mid_res_flags", 32'({res_cout, res_ovf, res_neg}), 32'd0);
    check("rst_mid_res_mag", 32'(res_mag), 32'd0);
    check("rst_mid_add_a", 32'(add_a), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_result", 32'(res_valid), 32'd0);
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
